// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with valid/ready flow control, a one-entry skid
// buffer, synchronous flush, zeroed control fields on bubbles and a
// saturating backpressure counter.
module id_exe_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int MEM_W  = 3,
    parameter int EXE_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    // Upstream (decode) side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] sign_extended,
    input  logic [REG_W-1:0]  instruction1,
    input  logic [REG_W-1:0]  instruction2,
    input  logic [WB_W-1:0]   WB,
    input  logic [MEM_W-1:0]  MEM,
    input  logic [EXE_W-1:0]  EXE,
    // Downstream (execute) side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pcOut,
    output logic [DATA_W-1:0] readData1Out,
    output logic [DATA_W-1:0] readData2Out,
    output logic [DATA_W-1:0] sign_extendedOut,
    output logic [REG_W-1:0]  instruction1Out,
    output logic [REG_W-1:0]  instruction2Out,
    output logic [WB_W-1:0]   WBOut,
    output logic [MEM_W-1:0]  MEMOut,
    output logic [EXE_W-1:0]  EXEOut,
    // Performance
    output logic [CNT_W-1:0]  stall_cycles
);

    // One beat is carried as a single packed vector so that main and skid
    // entries move as a unit.
    localparam int PAY_W = 4*DATA_W + 2*REG_W + WB_W + MEM_W + EXE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] m_q, m_d;    // main entry, drives the outputs
    logic [PAY_W-1:0] s_q, s_d;    // skid entry, absorbs one beat under backpressure
    logic             mv_q, mv_d;
    logic             sv_q, sv_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             in_fire;
    logic [WB_W-1:0]  m_wb;
    logic [MEM_W-1:0] m_mem;
    logic [EXE_W-1:0] m_exe;

    assign pay_in = {pc, readData1, readData2, sign_extended,
                     instruction1, instruction2, WB, MEM, EXE};

    // The skid entry being occupied is the only thing that blocks upstream,
    // so in_ready depends on registered state only (plus reset).
    assign in_ready = ~sv_q & ~reset;
    assign in_fire  = in_valid & in_ready;

    // Next-state for the two entries: EMPTY / ONE / FULL, flush overrides.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        m_d  = m_q;
        s_d  = s_q;
        mv_d = mv_q;
        sv_d = sv_q;

        if (!mv_q) begin
            // EMPTY
            if (in_fire) begin
                m_d  = pay_in;
                mv_d = 1'b1;
            end
        end else if (!sv_q) begin
            // ONE
            if (out_ready) begin
                if (in_fire) begin
                    m_d = pay_in;
                end else begin
                    mv_d = 1'b0;
                end
            end else if (in_fire) begin
                s_d  = pay_in;
                sv_d = 1'b1;
            end
        end else begin
            // FULL: upstream is blocked, only the skid beat can advance
            if (out_ready) begin
                m_d  = s_q;
                sv_d = 1'b0;
            end
        end

        // Flush squashes everything held after this edge; any beat accepted
        // this cycle is dropped, and the downstream transfer still completes.
        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
        end
    end

    // Saturating count of cycles where a valid beat is held but blocked.
    always_comb begin
        stall_d = stall_q;
        if (mv_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: payload is cleared too, since data outputs must read zero after reset.
            m_q     <= '0;
            s_q     <= '0;
            mv_q    <= 1'b0;
            sv_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            m_q     <= m_d;
            s_q     <= s_d;
            mv_q    <= mv_d;
            sv_q    <= sv_d;
            stall_q <= stall_d;
        end
    end

    assign {pcOut, readData1Out, readData2Out, sign_extendedOut,
            instruction1Out, instruction2Out, m_wb, m_mem, m_exe} = m_q;

    // Bubbles must never carry live control into execute/memory/writeback.
    assign WBOut        = mv_q ? m_wb  : '0;
    assign MEMOut       = mv_q ? m_mem : '0;
    assign EXEOut       = mv_q ? m_exe : '0;
    assign out_valid    = mv_q;
    assign stall_cycles = stall_q;

endmodule
